// File: rtl/seq_sdiv32by16_if.sv
// Operand/result handshake bundle for the iterative signed divider.
//   master: in_valid, dividend, divisor, out_ready  -> divider
//   slave : in_ready, out_valid, quotient, remainder, div_zero, ovf -> consumer
interface seq_sdiv32by16_if #(
    parameter int unsigned ND = 32,
    parameter int unsigned DD = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [ND-1:0] dividend;
    logic [DD-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [ND-1:0] quotient;
    logic [DD-1:0] remainder;
    logic          div_zero;
    logic          ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/seq_sdiv32by16.sv
// Iterative signed divider, ND-bit dividend by DD-bit divisor, radix-2 restoring.
// Sign-magnitude: magnitudes go through an unsigned core, signs are applied in FIX.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of seq_sdiv32by16_if (valid/ready operands in, valid/ready result out)
module seq_sdiv32by16 #(
    parameter int unsigned ND = 32,
    parameter int unsigned DD = 16
) (
    input  logic             clk,
    input  logic             rst,
    seq_sdiv32by16_if.slave  bus
);

    localparam int unsigned CW = $clog2(ND);
    localparam logic [ND-1:0] MIN_DVD = {1'b1, {(ND-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t        state_q;
    state_t        state_d;

    logic          in_ready_c;
    logic          out_valid_d;
    logic          out_valid_q;
    logic          accept;
    logic          div_zero_in;
    logic          ovf_in;

    logic          q_sign_q;
    logic          r_sign_q;
    logic          ovf_pend_q;
    logic [DD-1:0] dvs_abs_q;
    logic [DD-1:0] pr_q;
    logic [ND-1:0] sr_q;
    logic [CW-1:0] cnt_q;

    logic [ND-1:0] quotient_q;
    logic [DD-1:0] remainder_q;
    logic          div_zero_q;
    logic          ovf_q;

    logic [ND-1:0] dvd_abs;
    logic [DD-1:0] dvs_abs;
    logic [DD:0]   pr_shift;
    logic [DD:0]   trial;

    // Operand magnitudes; the most negative value maps onto itself, read as unsigned.
    assign dvd_abs     = bus.dividend[ND-1] ? (~bus.dividend + ND'(1)) : bus.dividend;
    assign dvs_abs     = bus.divisor[DD-1]  ? (~bus.divisor  + DD'(1)) : bus.divisor;
    assign div_zero_in = (bus.divisor == '0);
    assign ovf_in      = (bus.dividend == MIN_DVD) && (bus.divisor == '1);
    assign accept      = bus.in_valid & in_ready_c;

    // Partial remainder always stays below |divisor|, so DD bits hold it; the trial needs one more.
    assign pr_shift = {pr_q, sr_q[ND-1]};
    assign trial    = pr_shift - {1'b0, dvs_abs_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = div_zero_in ? DONE : ITER;
                end
            end
            ITER: begin
                if (cnt_q == CW'(ND - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; out_valid is registered one cycle after DONE is entered
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_d = 1'b0;
        if (state_q == IDLE) begin
            in_ready_c = 1'b1;
        end
        if ((state_q == DONE) && !(out_valid_q && bus.out_ready)) begin
            out_valid_d = 1'b1;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            q_sign_q    <= 1'b0;
            r_sign_q    <= 1'b0;
            ovf_pend_q  <= 1'b0;
            dvs_abs_q   <= '0;
            pr_q        <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        q_sign_q   <= bus.dividend[ND-1] ^ bus.divisor[DD-1];
                        r_sign_q   <= bus.dividend[ND-1];
                        ovf_pend_q <= ovf_in;
                        dvs_abs_q  <= dvs_abs;
                        sr_q       <= dvd_abs;
                        pr_q       <= '0;
                        cnt_q      <= '0;
                        div_zero_q <= div_zero_in;
                        ovf_q      <= 1'b0;
                        if (div_zero_in) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend[DD-1:0];
                        end
                    end
                end
                ITER: begin
                    // Restore on a negative trial by keeping the plain shifted value
                    pr_q  <= trial[DD] ? pr_shift[DD-1:0] : trial[DD-1:0];
                    sr_q  <= {sr_q[ND-2:0], ~trial[DD]};
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    quotient_q  <= q_sign_q ? (~sr_q + ND'(1)) : sr_q;
                    remainder_q <= r_sign_q ? (~pr_q + DD'(1)) : pr_q;
                    ovf_q       <= ovf_pend_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_sdiv32by16.sv
// Directed bench for seq_sdiv32by16: hand-computed quotients/remainders, latency,
// back-pressure hold, operand isolation after accept, and reset during iteration.
module tb_seq_sdiv32by16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seq_sdiv32by16_if #(.ND(32), .DD(16)) bus_if ();

    seq_sdiv32by16 #(.ND(32), .DD(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One complete operation: accept, scramble operands, wait for result, hold, handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input int exp_lat, input int hold,
                          input logic [31:0] eq, input logic [15:0] er,
                          input logic edz, input logic eovf);
        int lat;
        int busy_bad;
        bit seen;
        lat      = -1;
        busy_bad = 0;
        seen     = 1'b0;
        check({tag, ".idle"}, 32'(bus_if.in_ready), 32'd1);
        bus_if.dividend = a;
        bus_if.divisor  = b;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.dividend = 32'h5A5A_1234;
        bus_if.divisor  = 16'h0003;
        if (bus_if.in_ready) busy_bad++;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) begin
                seen = 1'b1;
                lat  = i;
            end else if (bus_if.in_ready) begin
                busy_bad++;
            end
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy"}, 32'(busy_bad), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_v"}, 32'(bus_if.out_valid), 32'd1);
            check({tag, ".hold_q"}, bus_if.quotient, eq);
        end
        check({tag, ".q"}, bus_if.quotient, eq);
        check({tag, ".r"}, 32'(bus_if.remainder), 32'(er));
        check({tag, ".dz"}, 32'(bus_if.div_zero), 32'(edz));
        check({tag, ".ovf"}, 32'(bus_if.ovf), 32'(eovf));
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check({tag, ".post_v"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, ".post_rdy"}, 32'(bus_if.in_ready), 32'd1);
        check({tag, ".post_q"}, bus_if.quotient, eq);
    endtask

    initial begin
        int stray;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.dividend  = '0;
        bus_if.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst.q", bus_if.quotient, 32'd0);
        check("rst.r", 32'(bus_if.remainder), 32'd0);
        check("rst.dz", 32'(bus_if.div_zero), 32'd0);
        check("rst.ovf", 32'(bus_if.ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("p100_7",   32'd100,        16'd7,      34, 0, 32'd14,        16'd2,      1'b0, 1'b0);
        run_op("n100_7",   32'hFFFF_FF9C,  16'd7,      34, 0, 32'hFFFF_FFF2, 16'hFFFE,   1'b0, 1'b0);
        run_op("p100_n7",  32'd100,        16'hFFF9,   34, 0, 32'hFFFF_FFF2, 16'd2,      1'b0, 1'b0);
        run_op("ovf",      32'h8000_0000,  16'hFFFF,   34, 0, 32'h8000_0000, 16'd0,      1'b0, 1'b1);
        run_op("dz",       32'd1234,       16'd0,       1, 0, 32'hFFFF_FFFF, 16'h04D2,   1'b1, 1'b0);
        run_op("max_min",  32'h7FFF_FFFF,  16'h8000,   34, 5, 32'hFFFF_0001, 16'h7FFF,   1'b0, 1'b0);

        // Reset while the counter reads 10 must abort without a result
        bus_if.dividend = 32'd100;
        bus_if.divisor  = 16'd7;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.in_ready", 32'(bus_if.in_ready), 32'd1);
        check("abort.out_valid", 32'(bus_if.out_valid), 32'd0);
        check("abort.q", bus_if.quotient, 32'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) stray++;
        end
        check("abort.stray_valid", 32'(stray), 32'd0);

        run_op("again",    32'd100,        16'd7,      34, 0, 32'd14,        16'd2,      1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
